// File: rtl/mux_rr_n.sv
// rtl/mux_rr_n.sv - N-channel registered valid/ready mux with round-robin or fixed selection
module mux_rr_n #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           sel_en,
  input  logic [SW-1:0]  sel,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch
);

  logic          ld;
  logic          xfer;
  logic [N-1:0]  g;
  logic [SW-1:0] gidx;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_next;
  logic [W-1:0]  g_data;
  logic [SW:0]   rr_sum;
  logic [SW-1:0] rr_idx;
  logic          rr_found;

  assign ld = !out_valid || out_ready;

  // Grant: fixed channel when sel_en, else first valid channel at or after ptr (mod N)
  always_comb begin
    g        = '0;
    gidx     = '0;
    rr_sum   = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    if (sel_en) begin
      if ({1'b0, sel} < (SW+1)'(N) && in_valid[sel]) begin
        g[sel] = 1'b1;
        gidx   = sel;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        rr_sum = {1'b0, ptr} + (SW+1)'(i);
        if (rr_sum >= (SW+1)'(N)) rr_sum = rr_sum - (SW+1)'(N);
        rr_idx = rr_sum[SW-1:0];
        if (!rr_found && in_valid[rr_idx]) begin
          rr_found  = 1'b1;
          g[rr_idx] = 1'b1;
          gidx      = rr_idx;
        end
      end
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) g_data = in_data[i*W +: W];
    end
  end

  // Reset gating keeps ready low even if a producer is valid during reset
  assign in_ready = (rst || !ld) ? '0 : g;
  assign xfer     = |in_ready;
  assign ptr_next = (gidx == SW'(N-1)) ? '0 : gidx + SW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= g_data;
        out_ch    <= gidx;
        if (!sel_en) ptr <= ptr_next;
      end else if (ld) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// tb/tb_mux_rr_n.sv - self-checking bench for mux_rr_n (N=4/W=8 and N=3/W=4)
module tb_mux_rr_n;

  logic        clk;
  logic        rst;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [31:0] a_in_data;
  logic        a_sel_en, a_out_valid, a_out_ready;
  logic [1:0]  a_sel, a_out_ch;
  logic [7:0]  a_out_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [11:0] b_in_data;
  logic        b_sel_en, b_out_valid, b_out_ready;
  logic [1:0]  b_sel, b_out_ch;
  logic [3:0]  b_out_data;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int         ma_ptr, mb_ptr;
  logic       ma_ov, mb_ov;
  logic [7:0] ma_od;
  logic [3:0] mb_od;
  int         ma_och, mb_och;

  mux_rr_n #(.N(4), .W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .sel_en(a_sel_en), .sel(a_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ch(a_out_ch));

  mux_rr_n #(.N(3), .W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .sel_en(b_sel_en), .sel(b_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ch(b_out_ch));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int ref_grant(input logic [3:0] v, input logic se, input int s,
                                   input int p, input int n);
    int c;
    if (se) return (s < n && v[s]) ? s : -1;
    for (int k = 0; k < n; k++) begin
      c = (p + k) % n;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic reset_models();
    ma_ptr = 0; ma_ov = 1'b0; ma_od = '0; ma_och = 0;
    mb_ptr = 0; mb_ov = 1'b0; mb_od = '0; mb_och = 0;
  endtask

  task automatic cyc_a(input logic [3:0] v, input logic [31:0] d, input logic se,
                       input logic [1:0] s, input logic ordy);
    int g;
    logic ld;
    logic [3:0] er;
    a_in_valid = v; a_in_data = d; a_sel_en = se; a_sel = s; a_out_ready = ordy;
    #1;
    ld = !ma_ov || ordy;
    g  = ref_grant(v, se, int'(s), ma_ptr, 4);
    er = (ld && g >= 0) ? 4'(1 << g) : 4'b0;
    chk("a_in_ready", 32'(a_in_ready), 32'(er));
    @(posedge clk);
    if (ld && g >= 0) begin
      ma_ov = 1'b1; ma_od = 8'(d >> (8 * g)); ma_och = g;
      if (!se) ma_ptr = (g + 1) % 4;
    end else if (ld) begin
      ma_ov = 1'b0;
    end
    #1;
    chk("a_out_valid", 32'(a_out_valid), 32'(ma_ov));
    chk("a_out_data", 32'(a_out_data), 32'(ma_od));
    chk("a_out_ch", 32'(a_out_ch), 32'(ma_och));
  endtask

  task automatic cyc_b(input logic [2:0] v, input logic [11:0] d, input logic se,
                       input logic [1:0] s, input logic ordy);
    int g;
    logic ld;
    logic [2:0] er;
    b_in_valid = v; b_in_data = d; b_sel_en = se; b_sel = s; b_out_ready = ordy;
    #1;
    ld = !mb_ov || ordy;
    g  = ref_grant({1'b0, v}, se, int'(s), mb_ptr, 3);
    er = (ld && g >= 0) ? 3'(1 << g) : 3'b0;
    chk("b_in_ready", 32'(b_in_ready), 32'(er));
    @(posedge clk);
    if (ld && g >= 0) begin
      mb_ov = 1'b1; mb_od = 4'(d >> (4 * g)); mb_och = g;
      if (!se) mb_ptr = (g + 1) % 3;
    end else if (ld) begin
      mb_ov = 1'b0;
    end
    #1;
    chk("b_out_valid", 32'(b_out_valid), 32'(mb_ov));
    chk("b_out_data", 32'(b_out_data), 32'(mb_od));
    chk("b_out_ch", 32'(b_out_ch), 32'(mb_och));
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 4'b1111; a_in_data = 32'hA3A2A1A0; a_sel_en = 1'b0; a_sel = '0; a_out_ready = 1'b1;
    b_in_valid = '0; b_in_data = '0; b_sel_en = 1'b0; b_sel = '0; b_out_ready = 1'b1;
    reset_models();
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_ch", 32'(a_out_ch), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    #2 rst = 1'b0;

    // Round-robin, all valid
    for (int i = 0; i < 6; i++) begin
      cyc_a(4'b1111, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b1);
      chk("rr_ch", 32'(a_out_ch), 32'(i % 4));
      chk("rr_data", 32'(a_out_data), 32'(8'hA0 + i % 4));
    end
    // Sparse, then wrap via ptr=3
    for (int i = 0; i < 4; i++) cyc_a(4'b1010, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b1);
    cyc_a(4'b0100, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b1);
    cyc_a(4'b0001, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b1);
    chk("wrap_ch", 32'(a_out_ch), 32'd0);
    cyc_a(4'b1111, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b1);
    chk("wrap_ptr1", 32'(a_out_ch), 32'd1);
    // Backpressure with A1 held
    for (int i = 0; i < 5; i++) begin
      cyc_a(4'b1111, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b0);
      chk("bp_hold", 32'(a_out_data), 32'hA1);
    end
    cyc_a(4'b1111, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b1);
    chk("bp_next", 32'(a_out_ch), 32'd2);
    // Fixed mode, drain, resume round-robin
    for (int i = 0; i < 3; i++) begin
      cyc_a(4'b1111, 32'hA3A2A1A0, 1'b1, 2'd2, 1'b1);
      chk("fix_ch", 32'(a_out_ch), 32'd2);
    end
    cyc_a(4'b1011, 32'hA3A2A1A0, 1'b1, 2'd2, 1'b1);
    chk("fix_drain", 32'(a_out_valid), 32'd0);
    cyc_a(4'b1111, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b1);
    chk("fix_resume", 32'(a_out_ch), 32'd3);
    // Randomised stream
    for (int i = 0; i < 300; i++)
      cyc_a(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 4) == 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    // Asynchronous reset between edges
    cyc_a(4'b1111, 32'h5A6B7C8D, 1'b0, 2'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(a_out_valid), 32'd0);
    chk("arst_out_data", 32'(a_out_data), 32'd0);
    chk("arst_out_ch", 32'(a_out_ch), 32'd0);
    chk("arst_in_ready", 32'(a_in_ready), 32'd0);
    reset_models();
    #3 rst = 1'b0;
    cyc_a(4'b1111, 32'hA3A2A1A0, 1'b0, 2'd0, 1'b1);
    chk("arst_first", 32'(a_out_ch), 32'd0);

    // Non-power-of-2 instance after a fresh reset
    a_in_valid = '0;
    #2 rst = 1'b1;
    reset_models();
    #3 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc_b(3'b111, 12'h987, 1'b0, 2'd0, 1'b1);
      chk("b_rr_ch", 32'(b_out_ch), 32'(i % 3));
    end
    cyc_b(3'b111, 12'h987, 1'b1, 2'd3, 1'b1);
    chk("b_sel3_ready", 32'(b_in_ready), 32'd0);
    for (int i = 0; i < 150; i++)
      cyc_b(3'($urandom_range(0, 7)), 12'($urandom), ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised N-channel, W-bit registered multiplexer. Each input channel and the output use a valid/ready handshake. Selection is either round-robin arbitration or a fixed channel chosen by `sel`. It sits between several producer streams and one consumer, and replaces ad-hoc combinational 4:1 selectors wherever fairness, backpressure or a registered output is needed.

## Interface
- `N`, default 4: number of input channels; N ≥ 2.
- `W`, default 8: data width per channel; W ≥ 1.
- `SW`, default `$clog2(N)`: width of the channel index. Derived, not to be overridden.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input N: per-channel valid; bit i belongs to channel i.
- `in_ready` output N: per-channel ready; combinational.
- `in_data` input N*W: channel i occupies bits [i*W +: W].
- `sel_en` input 1: 1 = fixed-select mode, 0 = round-robin mode.
- `sel` input SW: channel index used in fixed-select mode.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: consumer accepts a beat.
- `out_data` output W: registered selected data.
- `out_ch` output SW: registered index of the channel that supplied `out_data`.

## Operation
- State:
  - output register: `out_valid`, `out_data`, `out_ch`;
  - round-robin pointer `ptr` (SW bits).
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0, `ptr` = 0.
  - `in_ready` = all 0 while `rst` is high.
- Load enable: `ld = !out_valid || out_ready`.
- Grant selection, a one-hot vector `g` that may be all 0:
  - Fixed mode (`sel_en` = 1): `g[sel]` = `in_valid[sel]`; all other bits 0. A `sel` value ≥ N grants nothing.
  - Round-robin mode: grant the first channel with `in_valid` set, searching `ptr`, `ptr+1`, … `ptr+N-1`, all mod N. If no channel is valid, `g` = 0.
- `in_ready[i] = ld && g[i]`. A transfer on channel i is `in_valid[i] && in_ready[i]`; at most one transfer per cycle.
- On a clock edge:
  - With a transfer on channel k: `out_data` ← channel k data, `out_ch` ← k, `out_valid` ← 1.
  - With `ld` = 1 and no transfer: `out_valid` ← 0. `out_data` and `out_ch` hold their previous values.
  - With `ld` = 0: the output register holds.
- Pointer update:
  - Only on a transfer while in round-robin mode: `ptr` ← (k+1) mod N. For non-power-of-2 N the wrap is N-1 → 0.
  - Fixed-mode transfers never change `ptr`. Switching mode resumes round-robin from the retained `ptr`.
- Full throughput: with `out_ready` held at 1, one beat is accepted and one delivered every cycle.
- Reset during operation: any beat held in the output register is discarded. No partial state survives.

## Timing
- Latency: an input transfer at edge t makes `out_valid`/`out_data` visible after edge t, i.e. in cycle t+1.
- All outputs except `in_ready` are driven directly from flops.
- `in_ready` is combinational from `in_valid`, `sel_en`, `sel`, `out_valid`, `out_ready` and `ptr`.
  - There is no combinational path from any input to `out_*`.
- Handshake rules:
  - Producers must not make `in_valid` depend on `in_ready`.
  - Once `out_valid` = 1, `out_data` and `out_ch` stay stable until `out_ready` = 1.
- Simultaneous drain and refill: with `out_valid` = 1, `out_ready` = 1 and a granted input, the register is replaced in the same edge with no bubble.
- `sel` and `sel_en` are sampled every cycle. Changing them while `out_valid` = 1 does not alter the held beat.

## Test plan
- Reset: stream with N=4, W=8, then assert `rst` asynchronously between edges → `out_valid` = 0, `out_data` = 8'h00, `out_ch` = 0 immediately. After release, the first grant with `in_valid` = 4'b1111 is channel 0.
- Round-robin, all valid: `in_valid` = 4'b1111, channel i data = 8'hA0+i, `out_ready` = 1 → `out_ch` = 0,1,2,3,0,1 on consecutive cycles, `out_data` = A0,A1,A2,A3,A0,A1, first `out_valid` one cycle after the first edge.
- Sparse and wrap: `in_valid` = 4'b1010 → grants alternate 1,3,1,3. Then force `ptr` = 3 via a prior grant of channel 2 with `in_valid` = 4'b0001 → grant 0 and `ptr` = 1.
- Backpressure: `out_valid` = 1 with `out_data` = 8'hA1, hold `out_ready` = 0 for 5 cycles with all `in_valid` = 1 → `in_ready` = 4'b0000 and `out_data` stays 8'hA1. Raise `out_ready` → the next grant is channel 2 in the same edge.
- Fixed mode: `sel_en` = 1, `sel` = 2, `in_valid` = 4'b1111 → only channel 2 transfers, `out_ch` = 2 every cycle. Drop `in_valid[2]` → `out_valid` falls after the drain. Return to `sel_en` = 0 → round-robin resumes from the `ptr` held before fixed mode.
- Non-power-of-2: N=3, W=4, `in_valid` = 3'b111 → `out_ch` = 0,1,2,0. `sel` = 3 in fixed mode → no transfer and `in_ready` = 3'b000.
